// File: rtl/arb_pkg.sv
// Shared arbiter types and helpers: FSM state encoding, one-hot to index
// conversion and a width-limited rotate-left used by the priority picker.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_N = 16;

  function automatic logic [3:0] onehot_to_idx(input logic [15:0] i_oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      idx = idx | (i_oh[4'(i)] ? 4'(i) : 4'd0);
    end
    return idx;
  endfunction

  // Rotates the low n bits of v left by amt; bits at or above n are cleared.
  function automatic logic [15:0] rotate_left(input logic [15:0] v,
                                              input logic [4:0]  amt,
                                              input logic [4:0]  n);
    logic [15:0] rot;
    rot = 16'd0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (i < int'(n)) begin
        rot[4'((i + int'(amt)) % int'(n))] = v[4'(i)];
      end
    end
    return rot;
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational winner selection: masked request vector, round-robin search
// starting after rr_ptr, or lowest-index-wins when i_prio_mode is set.
module arb_prio_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_rr_ptr,
  input  logic             i_prio_mode,
  output logic [N-1:0]     o_winner_oh,
  output logic [IDX_W-1:0] o_winner_idx,
  output logic             o_any_req
);

  logic [15:0]      w_req16;
  logic [15:0]      w_rot;
  logic [15:0]      w_low;
  logic [3:0]       w_k;
  logic [IDX_W-1:0] w_idx;
  int               w_start;

  // Rotate so the search start sits at bit 0, isolate the lowest set bit,
  // then undo the rotation to get the absolute index.
  always_comb begin
    w_req16          = 16'd0;
    w_req16[N-1:0]   = i_req & ~i_mask;
    if (i_prio_mode) begin
      w_start = 32'sd0;
    end else begin
      w_start = (int'(i_rr_ptr) + 32'sd1) % N;
    end
    w_rot = rotate_left(w_req16, 5'((N - w_start) % N), 5'(N));
    w_low = w_rot & (~w_rot + 16'd1);
    w_k   = onehot_to_idx(w_low);
    w_idx = IDX_W'((int'(w_k) + w_start) % N);
  end

  // Outputs are forced to zero when nothing is requesting.
  always_comb begin
    o_any_req    = |w_req16;
    o_winner_oh  = '0;
    o_winner_idx = '0;
    if (o_any_req) begin
      o_winner_oh[w_idx] = 1'b1;
      o_winner_idx       = w_idx;
    end else begin
      o_winner_idx = '0;
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin / fixed-priority arbiter with held grants and
// registered one-hot + index outputs. Optional hold timeout: ARB_TIMEOUT_EN.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     req,
  input  logic             prio_mode,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  if (N < 2 || N > ARB_MAX_N || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arbiter_n: N must be 2..16 and MAX_HOLD at least 1");
  end

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [N-1:0]     r_gnt;
  logic [N-1:0]     w_gnt_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_valid;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             w_new_grant;
  logic             w_owner_req;
  logic             w_tmo;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;

  assign w_owner_req = |(req & r_gnt);

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = ($clog2(MAX_HOLD) > 4) ? $clog2(MAX_HOLD) : 4;
  logic [HC_W-1:0] r_hold_cnt;
  logic            w_hold_exp;

  assign w_hold_exp = (r_hold_cnt >= HC_W'(MAX_HOLD - 1));
  // Once the hold budget is spent the owner is hidden from the picker, so
  // w_any then means "some other requester is waiting".
  assign w_mask     = w_hold_exp ? r_gnt : '0;
  assign w_tmo      = w_hold_exp & w_any;

  // Hold counter: cleared on each new grant, saturates at MAX_HOLD-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold_cnt <= '0;
    end else if (w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_state == ARB_GRANT && !w_hold_exp) begin
      r_hold_cnt <= r_hold_cnt + HC_W'(1);
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end
`else
  assign w_mask = '0;
  assign w_tmo  = 1'b0;
`endif

  arb_prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req        (req),
    .i_mask       (w_mask),
    .i_rr_ptr     (r_rr_ptr),
    .i_prio_mode  (prio_mode),
    .o_winner_oh  (w_win_oh),
    .o_winner_idx (w_win_idx),
    .o_any_req    (w_any)
  );

  // Next-state logic: an owner that drops while others wait hands over on the
  // same edge, so there is no idle bubble between back-to-back grants.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    w_new_grant = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_GRANT;
          w_gnt_nxt   = w_win_oh;
          w_idx_nxt   = w_win_idx;
          w_new_grant = 1'b1;
        end else begin
          w_gnt_nxt = '0;
          w_idx_nxt = '0;
        end
      end
      ARB_GRANT: begin
        if (w_owner_req && !w_tmo) begin
          w_state_nxt = ARB_GRANT;
        end else if (w_any) begin
          w_state_nxt = ARB_GRANT;
          w_gnt_nxt   = w_win_oh;
          w_idx_nxt   = w_win_idx;
          w_new_grant = 1'b1;
        end else begin
          w_state_nxt = ARB_IDLE;
          w_gnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, output and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_valid   <= 1'b0;
      r_rr_ptr  <= IDX_W'(N - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_valid   <= |w_gnt_nxt;
      if (w_new_grant) begin
        r_rr_ptr <= w_win_idx;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n (N=4, MAX_HOLD=8): vector table,
// hand-written corner sequences and a randomized run against an integer model.
module tb_rr_arbiter_n;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req;
  logic             prio_mode;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  rr_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .prio_mode (prio_mode),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owner index (-1 = idle), pointer, hold cycles.
  int m_owner;
  int m_ptr;
  int m_hold;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         mode;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr,
                              input bit mode, input int excl);
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        if (r[i] && i != excl) return i;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (r[j] && j != excl) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_hold  = 0;
  endtask

  task automatic model_edge();
    int  w;
    bit  tmo;
    if (!rstn) begin
      model_reset();
    end else if (m_owner < 0) begin
      w = pick(req, m_ptr, prio_mode, -1);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_hold = 0;
      end
    end else begin
      tmo = TMO && (m_hold >= MAX_HOLD - 1) && (pick(req, m_ptr, prio_mode, m_owner) >= 0);
      if (req[m_owner] && !tmo) begin
        if (m_hold < MAX_HOLD - 1) m_hold++;
      end else begin
        w = pick(req, m_ptr, prio_mode, m_owner);
        if (w >= 0) begin
          m_owner = w; m_ptr = w; m_hold = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    int exp_gnt;
    exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
    chk({tag, "_gnt"},     int'(gnt),       exp_gnt);
    chk({tag, "_valid"},   int'(gnt_valid), (m_owner < 0) ? 0 : 1);
    chk({tag, "_idx"},     int'(gnt_idx),   (m_owner < 0) ? 0 : m_owner);
    chk({tag, "_onehot0"}, int'($onehot0(gnt)), 1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    req       = '0;
    rstn      = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int first;
    rstn      = 1'b1;
    req       = '0;
    prio_mode = 1'b0;
    model_reset();

    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0001};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0001};
    vecs[3]  = '{1'b0, 4'b1110, 1'b0, 4'b0010};
    vecs[4]  = '{1'b0, 4'b1101, 1'b0, 4'b0100};
    vecs[5]  = '{1'b0, 4'b1011, 1'b0, 4'b1000};
    vecs[6]  = '{1'b0, 4'b0111, 1'b0, 4'b0001};
    vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0110, 1'b1, 4'b0010};
    vecs[9]  = '{1'b0, 4'b0111, 1'b1, 4'b0010};
    vecs[10] = '{1'b0, 4'b0101, 1'b1, 4'b0001};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000};
    vecs[12] = '{1'b0, 4'b1001, 1'b0, 4'b1000};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000};

    #2;
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].rst) do_reset();
      req       = vecs[v].req;
      prio_mode = vecs[v].mode;
      step("vec");
      chk($sformatf("vec%0d_table", v), int'(gnt), int'(vecs[v].exp));
    end

    // Asynchronous reset in the middle of a grant.
    do_reset();
    prio_mode = 1'b0;
    req       = 4'b0100;
    step("arst_pre");
    chk("arst_pre_table", int'(gnt), 4);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_model("arst_now");
    chk("arst_now_table", int'(gnt), 0);
    @(posedge clk);
    #1;
    check_model("arst_hold");
    rstn = 1'b1;
    req  = 4'b1100;
    step("arst_post");
    chk("arst_post_table", int'(gnt), 4);

    // Long hold by requester 2 with requester 3 competing from cycle 2.
    do_reset();
    req = 4'b0100;
    step("hold");
    req   = 4'b1100;
    first = -1;
    for (int c = 2; c <= 20; c++) begin
      step("hold");
      if (gnt == 4'b1000 && first < 0) first = c;
    end
    chk("hold_switch_cycle", first, TMO ? 9 : -1);

    // Randomized run with persistent requests, mode flips and rare resets.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) prio_mode = ~prio_mode;
      if ($urandom_range(0, 99) == 0) begin
        rstn = 1'b0;
        model_reset();
        #1;
        check_model("rand_arst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
